// File: rtl/wash_pkg.sv
// Shared types for the wash cycle sequencer: state encoding, program descriptor, default widths.
package wash_pkg;

  localparam int unsigned LevelW = 10;
  localparam int unsigned TempW  = 7;
  localparam int unsigned SpeedW = 11;
  localparam int unsigned TimeW  = 12;
  localparam int unsigned RinseW = 2;

  typedef enum logic [3:0] {
    StIdle      = 4'd0,
    StFillHeat  = 4'd1,
    StWash      = 4'd2,
    StDrain     = 4'd3,
    StRinseFill = 4'd4,
    StRinse     = 4'd5,
    StSpin      = 4'd6,
    StDone      = 4'd7,
    StPaused    = 4'd8,
    StAbort     = 4'd9
  } wash_state_e;

  typedef struct packed {
    logic [LevelW-1:0] target_level;
    logic [TempW-1:0]  target_temp;
    logic [SpeedW-1:0] spin_speed;
    logic [TimeW-1:0]  wash_time;
    logic [TimeW-1:0]  rinse_time;
    logic [TimeW-1:0]  spin_time;
    logic [RinseW-1:0] rinse_count;
  } wash_desc_t;

  // States whose duration comes from the phase timer.
  function automatic logic is_timed(wash_state_e s);
    return s inside {StWash, StRinse, StSpin};
  endfunction

  // States guarded by the fill/drain watchdog.
  function automatic logic is_wdog(wash_state_e s);
    return s inside {StFillHeat, StRinseFill, StDrain, StAbort};
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter advanced by a tick strobe; holds at zero and while frozen.
module phase_timer #(
  parameter int unsigned Width = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             tick,
  input  logic             freeze,
  output logic [Width-1:0] count,
  output logic             zero
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (tick && !freeze && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Washing-machine program sequencer: fill/heat, wash, rinse loops, spin, with
// internal phase timing, fill/drain watchdog, pause/resume and abort-drain.
module wash_cycle_sequencer
  import wash_pkg::*;
#(
  parameter int unsigned LEVEL_W    = LevelW,
  parameter int unsigned TEMP_W     = TempW,
  parameter int unsigned SPEED_W    = SpeedW,
  parameter int unsigned TIME_W     = TimeW,
  parameter int unsigned RINSE_W    = RinseW,
  parameter int unsigned WDOG_TICKS = 600
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               resume,
  input  logic               door_closed,
  input  logic               clothes_loaded,
  input  logic               vibration_sensor,
  input  logic [LEVEL_W-1:0] water_level_sensor,
  input  logic [TEMP_W-1:0]  temp_sensor,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [LEVEL_W-1:0] cfg_target_level,
  input  logic [TEMP_W-1:0]  cfg_target_temp,
  input  logic [SPEED_W-1:0] cfg_spin_speed,
  input  logic [TIME_W-1:0]  cfg_wash_time,
  input  logic [TIME_W-1:0]  cfg_rinse_time,
  input  logic [TIME_W-1:0]  cfg_spin_time,
  input  logic [RINSE_W-1:0] cfg_rinse_count,
  output logic               door_lock,
  output logic               water_valve,
  output logic               detergent_valve,
  output logic               heater,
  output logic               drain_pump,
  output logic [SPEED_W-1:0] drum_motor,
  output logic [3:0]         state_o,
  output logic [RINSE_W-1:0] rinse_idx,
  output logic [TIME_W-1:0]  remaining_time,
  output logic               busy,
  output logic               cycle_done,
  output logic               err_fill,
  output logic               err_drain,
  output logic               err_vibration
);

  wash_state_e        state_q, state_d, ret_q, ret_d;
  wash_desc_t         desc_q, desc_d;
  logic [RINSE_W-1:0] rinse_q, rinse_d;
  logic               err_fill_q, err_fill_d, err_drain_q, err_drain_d, err_vib_q, err_vib_d;

  logic              running, active, need_fill, need_heat, level_empty;
  logic              phase_load, phase_zero, phase_end, wdog_zero;
  logic [TIME_W-1:0] phase_value, phase_count, unused_wdog_count;

  assign running     = !(state_q inside {StIdle, StDone});
  assign active      = running && !(state_q inside {StPaused, StAbort});
  assign need_fill   = water_level_sensor < desc_q.target_level;
  assign need_heat   = temp_sensor < desc_q.target_temp;
  assign level_empty = (water_level_sensor == '0);
  assign phase_end   = phase_zero || (tick && (phase_count == TIME_W'(1)));

  // Returning from PAUSED keeps the frozen phase count instead of reloading it.
  assign phase_load = (state_d != state_q) && is_timed(state_d) && (state_q != StPaused);

  always_comb begin
    case (state_d)
      StWash:  phase_value = desc_q.wash_time;
      StRinse: phase_value = desc_q.rinse_time;
      default: phase_value = desc_q.spin_time;
    endcase
  end

  phase_timer #(.Width(TIME_W)) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (phase_load),
    .load_value (phase_value),
    .tick       (tick),
    .freeze     (!is_timed(state_q)),
    .count      (phase_count),
    .zero       (phase_zero)
  );

  phase_timer #(.Width(TIME_W)) u_wdog_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (state_d != state_q),
    .load_value (TIME_W'(WDOG_TICKS)),
    .tick       (tick),
    .freeze     (!is_wdog(state_q)),
    .count      (unused_wdog_count),
    .zero       (wdog_zero)
  );

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    desc_d      = desc_q;
    rinse_d     = rinse_q;
    err_fill_d  = err_fill_q;
    err_drain_d = err_drain_q;
    err_vib_d   = err_vib_q;
    if (running && stop) begin
      state_d = StAbort;
    end else if (state_q == StPaused) begin
      if (vibration_sensor) begin
        err_vib_d = 1'b1;
      end else if (resume) begin
        err_fill_d  = 1'b0;
        err_drain_d = 1'b0;
        err_vib_d   = 1'b0;
        state_d     = ret_q;
      end
    end else if (active && vibration_sensor) begin
      err_vib_d = 1'b1;
      state_d   = StPaused;
      ret_d     = state_q;
    end else if (active && wdog_zero && is_wdog(state_q)) begin
      if (state_q == StDrain) err_drain_d = 1'b1;
      else                    err_fill_d  = 1'b1;
      state_d = StPaused;
      ret_d   = state_q;
    end else if (active && pause) begin
      state_d = StPaused;
      ret_d   = state_q;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && cfg_valid && door_closed && clothes_loaded) begin
            desc_d.target_level = cfg_target_level;
            desc_d.target_temp  = cfg_target_temp;
            desc_d.spin_speed   = cfg_spin_speed;
            desc_d.wash_time    = cfg_wash_time;
            desc_d.rinse_time   = cfg_rinse_time;
            desc_d.spin_time    = cfg_spin_time;
            desc_d.rinse_count  = cfg_rinse_count;
            rinse_d             = '0;
            state_d             = StFillHeat;
          end
        end
        StFillHeat:  if (!need_fill && !need_heat) state_d = StWash;
        StWash:      if (phase_end) state_d = StDrain;
        StDrain: begin
          if (level_empty) state_d = (rinse_q < desc_q.rinse_count) ? StRinseFill : StSpin;
        end
        StRinseFill: if (!need_fill) state_d = StRinse;
        StRinse: begin
          if (phase_end) begin
            state_d = StDrain;
            rinse_d = rinse_q + RINSE_W'(1);
          end
        end
        StSpin:      if (phase_end) state_d = StDone;
        StDone:      state_d = StIdle;
        StAbort: begin
          if (vibration_sensor) err_vib_d = 1'b1;
          if (wdog_zero) err_drain_d = 1'b1;
          // Reaching empty ends the abort and wipes the run's status.
          if (level_empty) begin
            state_d     = StIdle;
            err_fill_d  = 1'b0;
            err_drain_d = 1'b0;
            err_vib_d   = 1'b0;
            rinse_d     = '0;
          end
        end
        default:     state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cfg_ready       = (state_q == StIdle);
    busy            = running;
    door_lock       = running;
    water_valve     = 1'b0;
    detergent_valve = 1'b0;
    heater          = 1'b0;
    drain_pump      = 1'b0;
    drum_motor      = '0;
    cycle_done      = 1'b0;
    case (state_q)
      StFillHeat: begin
        water_valve     = need_fill;
        detergent_valve = need_fill;
        heater          = need_heat;
      end
      StWash, StRinse, StSpin: drum_motor = desc_q.spin_speed;
      StRinseFill:             water_valve = need_fill;
      StDrain, StAbort:        drain_pump = 1'b1;
      StDone:                  cycle_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      ret_q       <= StIdle;
      desc_q      <= '0;
      rinse_q     <= '0;
      err_fill_q  <= 1'b0;
      err_drain_q <= 1'b0;
      err_vib_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      desc_q      <= desc_d;
      rinse_q     <= rinse_d;
      err_fill_q  <= err_fill_d;
      err_drain_q <= err_drain_d;
      err_vib_q   <= err_vib_d;
    end
  end

  assign state_o        = state_q;
  assign rinse_idx      = rinse_q;
  assign remaining_time = phase_count;
  assign err_fill       = err_fill_q;
  assign err_drain      = err_drain_q;
  assign err_vibration  = err_vib_q;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed bench: expected state sequences queued at launch and checked against observed transitions.
module tb_wash_cycle_sequencer;
  import wash_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, tick, start, stop, pause, resume;
  logic        door_closed, clothes_loaded, vibration_sensor;
  logic [9:0]  water_level_sensor;
  logic [6:0]  temp_sensor;
  logic        cfg_valid, cfg_ready;
  logic [9:0]  cfg_target_level;
  logic [6:0]  cfg_target_temp;
  logic [10:0] cfg_spin_speed;
  logic [11:0] cfg_wash_time, cfg_rinse_time, cfg_spin_time;
  logic [1:0]  cfg_rinse_count;
  logic        door_lock, water_valve, detergent_valve, heater, drain_pump;
  logic [10:0] drum_motor;
  logic [3:0]  state_o;
  logic [1:0]  rinse_idx;
  logic [11:0] remaining_time;
  logic        busy, cycle_done, err_fill, err_drain, err_vibration;

  wash_cycle_sequencer dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop), .pause(pause),
    .resume(resume), .door_closed(door_closed), .clothes_loaded(clothes_loaded),
    .vibration_sensor(vibration_sensor), .water_level_sensor(water_level_sensor),
    .temp_sensor(temp_sensor), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_target_level(cfg_target_level), .cfg_target_temp(cfg_target_temp),
    .cfg_spin_speed(cfg_spin_speed), .cfg_wash_time(cfg_wash_time),
    .cfg_rinse_time(cfg_rinse_time), .cfg_spin_time(cfg_spin_time),
    .cfg_rinse_count(cfg_rinse_count), .door_lock(door_lock), .water_valve(water_valve),
    .detergent_valve(detergent_valve), .heater(heater), .drain_pump(drain_pump),
    .drum_motor(drum_motor), .state_o(state_o), .rinse_idx(rinse_idx),
    .remaining_time(remaining_time), .busy(busy), .cycle_done(cycle_done),
    .err_fill(err_fill), .err_drain(err_drain), .err_vibration(err_vibration)
  );

  int          tests = 0;
  int          fails = 0;
  int          exp_q[$];
  int          obs_q[$];
  int          rd = 0;
  int          done_cnt = 0;
  int          wash_cycles = 0;
  int          watch_ticks = 0;
  logic [3:0]  watch_st = 4'd0;
  logic [3:0]  last_state = 4'd0;
  logic [10:0] drum_wash = '0;
  logic        tick_ph = 1'b0;
  logic        hold_level = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive tick, sample #1 after the edge, log transitions, advance the plant.
  task automatic cyc();
    tick    = tick_ph;
    tick_ph = !tick_ph;
    if (tick && (state_o == watch_st)) watch_ticks++;
    @(posedge clk);
    #1;
    if (state_o !== last_state) begin
      obs_q.push_back(int'(state_o));
      last_state = state_o;
    end
    if (cycle_done) done_cnt++;
    if (state_o == StWash) begin
      wash_cycles++;
      drum_wash = drum_motor;
    end
    if (!hold_level) begin
      if (water_valve && water_level_sensor < 10'd1000) water_level_sensor += 10'd5;
      if (drain_pump) water_level_sensor = (water_level_sensor >= 10'd5) ?
                                           water_level_sensor - 10'd5 : 10'd0;
    end
    if (heater && temp_sensor < 7'd127) temp_sensor += 7'd1;
  endtask

  task automatic run_until(input logic [3:0] st, input int max, input string tag);
    int n = 0;
    while (state_o !== st && n < max) begin
      cyc();
      n++;
    end
    chk(tag, 32'(state_o), 32'(st));
  endtask

  task automatic launch(input logic [11:0] wt, input logic [11:0] rt, input logic [11:0] st,
                        input logic [1:0] rc);
    cfg_target_level = 10'd100;
    cfg_target_temp  = 7'd40;
    cfg_spin_speed   = 11'd800;
    cfg_wash_time    = wt;
    cfg_rinse_time   = rt;
    cfg_spin_time    = st;
    cfg_rinse_count  = rc;
    cfg_valid = 1'b1; start = 1'b1; door_closed = 1'b1; clothes_loaded = 1'b1;
    cyc();
    start = 1'b0; cfg_valid = 1'b0;
    // Scramble the descriptor; the latched copy must be the one in use.
    cfg_target_level = 10'd999; cfg_spin_speed = 11'd5; cfg_wash_time = 12'd4000;
    cfg_rinse_count = 2'd3;
  endtask

  task automatic score(input string tag);
    int e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd < obs_q.size()) begin
        chk(tag, obs_q[rd], e);
        rd++;
      end else begin
        chk({tag, "_missing"}, 32'hFFFF_FFFF, e);
      end
    end
    chk({tag, "_extra"}, rd, obs_q.size());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; resume = 1'b0;
    door_closed = 1'b0; clothes_loaded = 1'b0; vibration_sensor = 1'b0; cfg_valid = 1'b0;
    water_level_sensor = '0; temp_sensor = 7'd20;
    cfg_target_level = '0; cfg_target_temp = '0; cfg_spin_speed = '0;
    cfg_wash_time = '0; cfg_rinse_time = '0; cfg_spin_time = '0; cfg_rinse_count = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state_o), 32'(StIdle));
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_outputs", 32'({door_lock, water_valve, detergent_valve, heater, drain_pump, busy,
                           cycle_done, err_fill, err_drain, err_vibration}), 32'd0);
    chk("rst_drum", 32'(drum_motor), 32'd0);
    chk("rst_remaining", 32'(remaining_time), 32'd0);
    reset = 1'b1;
    cyc();

    // Full program with two rinses.
    exp_q = {StFillHeat, StWash, StDrain, StRinseFill, StRinse, StDrain, StRinseFill, StRinse,
             StDrain, StSpin, StDone, StIdle};
    done_cnt = 0;
    launch(12'd5, 12'd2, 12'd3, 2'd2);
    run_until(StIdle, 3000, "full_end");
    score("full_seq");
    chk("full_done_pulses", done_cnt, 32'd1);
    chk("full_rinse_idx", 32'(rinse_idx), 32'd2);
    chk("full_drum_wash", 32'(drum_wash), 32'd800);

    // Zero wash time, no rinses.
    exp_q = {StFillHeat, StWash, StDrain, StSpin, StDone, StIdle};
    wash_cycles = 0;
    launch(12'd0, 12'd2, 12'd2, 2'd0);
    run_until(StIdle, 2000, "short_end");
    score("short_seq");
    chk("short_wash_cycles", wash_cycles, 32'd1);

    // Pause in WASH at remaining_time 3 on a tick-free cycle.
    exp_q = {StFillHeat, StWash, StPaused, StWash, StDrain, StSpin, StDone, StIdle};
    launch(12'd6, 12'd2, 12'd1, 2'd0);
    for (int n = 0; n < 500 && !(state_o == StWash && remaining_time == 12'd3); n++) cyc();
    chk("pause_point", 32'(remaining_time), 32'd3);
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    chk("pause_enter", 32'(state_o), 32'(StPaused));
    repeat (100) cyc();
    chk("pause_hold", 32'(state_o), 32'(StPaused));
    chk("pause_drum", 32'(drum_motor), 32'd0);
    chk("pause_frozen", 32'(remaining_time), 32'd3);
    chk("pause_lock", 32'(door_lock), 32'd1);
    watch_st = StWash; watch_ticks = 0;
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    chk("resume_state", 32'(state_o), 32'(StWash));
    chk("resume_remaining", 32'(remaining_time), 32'd3);
    run_until(StDrain, 100, "resume_drain");
    chk("resume_ticks", watch_ticks, 32'd3);
    run_until(StIdle, 500, "pause_end");
    score("pause_seq");

    // Fill watchdog with a stuck level sensor.
    exp_q = {StFillHeat, StPaused, StFillHeat, StAbort, StIdle};
    hold_level = 1'b1; water_level_sensor = '0;
    watch_st = StFillHeat; watch_ticks = 0;
    launch(12'd1, 12'd1, 12'd1, 2'd0);
    run_until(StPaused, 1500, "wdog_pause");
    chk("wdog_ticks", watch_ticks, 32'd600);
    chk("wdog_err_fill", 32'(err_fill), 32'd1);
    chk("wdog_err_drain", 32'(err_drain), 32'd0);
    chk("wdog_valve_off", 32'(water_valve), 32'd0);
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    chk("wdog_resume_state", 32'(state_o), 32'(StFillHeat));
    chk("wdog_resume_clear", 32'(err_fill), 32'd0);
    repeat (1100) cyc();
    chk("wdog_restart_state", 32'(state_o), 32'(StFillHeat));
    chk("wdog_restart_err", 32'(err_fill), 32'd0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("wdog_abort", 32'(state_o), 32'(StAbort));
    run_until(StIdle, 50, "wdog_idle");
    hold_level = 1'b0;
    score("wdog_seq");

    // Vibration in SPIN, then stop while paused.
    exp_q = {StFillHeat, StWash, StDrain, StSpin, StPaused, StAbort, StIdle};
    launch(12'd1, 12'd1, 12'd20, 2'd0);
    run_until(StSpin, 500, "vib_spin");
    vibration_sensor = 1'b1;
    cyc();
    vibration_sensor = 1'b0;
    chk("vib_paused", 32'(state_o), 32'(StPaused));
    chk("vib_flag", 32'(err_vibration), 32'd1);
    chk("vib_drum", 32'(drum_motor), 32'd0);
    hold_level = 1'b1; water_level_sensor = 10'd50; stop = 1'b1;
    cyc();
    stop = 1'b0; hold_level = 1'b0;
    chk("abort_state", 32'(state_o), 32'(StAbort));
    chk("abort_acts", 32'({drain_pump, water_valve, detergent_valve, heater, door_lock}),
        32'b10001);
    chk("abort_flag_kept", 32'(err_vibration), 32'd1);
    run_until(StIdle, 100, "abort_idle");
    chk("abort_flags_clear", 32'({err_fill, err_drain, err_vibration}), 32'd0);
    chk("abort_rinse_clear", 32'(rinse_idx), 32'd0);
    score("vib_seq");

    // Asynchronous reset in the middle of RINSE.
    exp_q = {StFillHeat, StWash, StDrain, StRinseFill, StRinse, StIdle};
    launch(12'd1, 12'd10, 12'd1, 2'd1);
    run_until(StRinse, 1000, "rst_rinse");
    reset = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 32'(StIdle));
    chk("arst_outputs", 32'({door_lock, water_valve, detergent_valve, heater, drain_pump, busy,
                            cycle_done, err_fill, err_drain, err_vibration}), 32'd0);
    chk("arst_drum", 32'(drum_motor), 32'd0);
    chk("arst_timer", 32'(remaining_time), 32'd0);
    chk("arst_rinse", 32'(rinse_idx), 32'd0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("arst_release_state", 32'(state_o), 32'(StIdle));
    chk("arst_release_ready", 32'(cfg_ready), 32'd1);
    score("rst_seq");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wash_cycle_sequencer.md
Name: wash_cycle_sequencer

Overview:
Parametrised successor to the washing-machine controller FSM. Sequences fill/heat, wash, N rinse loops and spin from a latched program descriptor. Phase timing and fill/drain watchdogs are internal, driven by a tick timebase, so no external timer block is needed. Sits between the front-panel program selector (valid/ready config handshake) and the actuator/sensor interface.

Parameters:
LEVEL_W, 10, water level sensor/target width
TEMP_W, 7, temperature sensor/target width
SPEED_W, 11, drum speed width
TIME_W, 12, phase duration width (ticks)
RINSE_W, 2, rinse count width (max 2^RINSE_W-1 rinses)
WDOG_TICKS, 600, max ticks allowed in any fill or drain state before error

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle timebase strobe
start, stop, pause, resume  in  1 each  panel commands, level-sampled
door_closed, clothes_loaded, vibration_sensor  in  1 each  sensors
water_level_sensor  in  LEVEL_W  current level
temp_sensor  in  TEMP_W  current temperature
cfg_valid  in  1  descriptor valid
cfg_ready  out  1  high only in IDLE
cfg_target_level  in  LEVEL_W;  cfg_target_temp  in  TEMP_W;  cfg_spin_speed  in  SPEED_W
cfg_wash_time, cfg_rinse_time, cfg_spin_time  in  TIME_W each
cfg_rinse_count  in  RINSE_W
door_lock, water_valve, detergent_valve, heater, drain_pump  out  1 each  actuators
drum_motor  out  SPEED_W  speed command
state_o  out  4  current state encoding
rinse_idx  out  RINSE_W  completed rinses
remaining_time  out  TIME_W  phase timer value
busy  out  1  state not IDLE/DONE
cycle_done  out  1  one-cycle pulse on DONE entry
err_fill, err_drain, err_vibration  out  1 each  sticky error flags

Behaviour:
- Reset (reset=0, async): state IDLE, all registers 0; cfg_ready=1, every other output 0.
- States: IDLE, FILL_HEAT, WASH, DRAIN, RINSE_FILL, RINSE, SPIN, DONE, PAUSED, ABORT.
- IDLE: door_lock=0. start&cfg_valid&door_closed&clothes_loaded latches all cfg_* fields into internal registers, clears rinse_idx, and moves to FILL_HEAT next cycle. cfg_* changes while busy are ignored.
- FILL_HEAT: water_valve=detergent_valve=(level<target_level); heater=(temp<target_temp). Exit to WASH in the first cycle where both are false.
- WASH/RINSE/SPIN: phase timer loads the cfg time on entry and decrements on each tick. The phase ends on tick with timer==1; a loaded value of 0 ends it in the entry cycle. drum_motor=spin_speed. WASH->DRAIN; RINSE->DRAIN with rinse_idx+1; SPIN->DONE.
- RINSE_FILL: water_valve=(level<target_level). Exit to RINSE when level>=target.
- DRAIN: drain_pump=1, drum 0. When level==0: go to RINSE_FILL if rinse_idx<rinse_count, else SPIN. rinse_count=0 goes WASH->DRAIN->SPIN.
- DONE: cycle_done pulses, door_lock=0; returns to IDLE next cycle.
- door_lock=1 in every state except IDLE/DONE.
- Watchdog: counts ticks in FILL_HEAT, RINSE_FILL, DRAIN, ABORT and reloads on state entry. Reaching WDOG_TICKS sets err_fill (fill states) or err_drain (DRAIN) and forces PAUSED. In ABORT it only sets err_drain and draining continues.
- Priority each cycle: stop > vibration_sensor > watchdog expiry > pause > normal transition.
- stop in any busy state, PAUSED included -> ABORT. ABORT: drain_pump=1, all other actuators 0, door locked. level==0 -> IDLE, clearing err flags and rinse_idx.
- vibration_sensor in a busy non-ABORT state sets err_vibration and forces PAUSED. In ABORT it sets the flag only.
- pause in IDLE/DONE/ABORT/PAUSED is ignored.
- PAUSED: all actuators 0, door locked. The return state is saved on entry; the phase timer is frozen, not reloaded. resume (with no stop) clears all err flags and returns to the saved state next cycle, restarting the watchdog. A resume and vibration in the same cycle: vibration wins, so the block stays PAUSED.
- Timer and watchdog saturate at 0; no wrap.

Decomposition:
- Package wash_pkg: state enum (4-bit), descriptor struct (all cfg_* fields), widths as localparams.
- Sub-module phase_timer: loadable TIME_W down-counter with tick enable, freeze and zero flag. Instantiated twice, once for the phase timer and once for the watchdog.

Test Plan:
- Full cycle: target_level=100, target_temp=40, wash=5, rinse=2, spin=3, rinse_count=2, ideal sensor model -> visits FILL_HEAT,WASH,DRAIN,(RINSE_FILL,RINSE,DRAIN)x2,SPIN,DONE; cycle_done pulses once; rinse_idx ends at 2.
- rinse_count=0, wash_time=0 -> WASH lasts 1 cycle, DRAIN goes straight to SPIN, no RINSE_FILL visited.
- Pause during WASH at remaining_time=3, hold 50 ticks, resume -> drum 0 while paused; WASH resumes with remaining_time=3, then 3 more ticks to DRAIN.
- Level held at 0 in FILL_HEAT for 600 ticks -> err_fill=1 and PAUSED; resume clears err_fill and the watchdog restarts.
- vibration_sensor pulsed during SPIN, then stop asserted -> PAUSED with err_vibration=1, then ABORT with drain_pump=1; level 0 -> IDLE with all flags 0.
- reset pulsed low mid-RINSE -> all outputs 0 immediately (async); after release the state is IDLE and cfg_ready=1.
